// File: rtl/stim_seq_pkg.sv
// Shared widths, MISR constants and FSM state type for the stimulus sequencer.
package stim_seq_pkg;

    localparam int unsigned IN_W  = 64;
    localparam int unsigned OUT_W = 474;
    localparam int unsigned SIG_W = 32;

    localparam logic [SIG_W-1:0] MISR_POLY = 32'h04C1_1DB7;
    localparam logic [SIG_W-1:0] MISR_SEED = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StSettle  = 2'd1,
        StCapture = 2'd2,
        StDone    = 2'd3
    } seq_state_t;

endpackage

// File: rtl/stim_misr.sv
// Multiple-input signature register: folds a wide sample into SIG_W bits and
// shifts it into a CRC-32 polynomial register.
module stim_misr
    import stim_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             en,
    input  logic [OUT_W-1:0] data,
    output logic [SIG_W-1:0] sig
);

    localparam int unsigned FOLD_N = (OUT_W + SIG_W - 1) / SIG_W;
    localparam int unsigned PAD_W  = FOLD_N * SIG_W;

    logic [PAD_W-1:0] padded;
    logic [SIG_W-1:0] fold;
    logic [SIG_W-1:0] sig_d;

    // Zero-pad the sample to a whole number of slices, XOR them, then shift.
    always_comb begin
        padded = PAD_W'(data);
        fold   = '0;
        for (int unsigned i = 0; i < FOLD_N; i++) begin
            fold = fold ^ padded[i*SIG_W +: SIG_W];
        end
        sig_d = {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? MISR_POLY : '0) ^ fold;
    end

    // Signature register; clear has priority over an update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sig <= MISR_SEED;
        end else if (clear) begin
            sig <= MISR_SEED;
        end else if (en) begin
            sig <= sig_d;
        end
    end

endmodule

// File: rtl/stim_sequencer.sv
// Cycle-exact stimulus sequencer: replays stored vectors into the datapath,
// samples its output after a programmable settle time and compresses the
// samples into a signature compared against a golden value.
module stim_sequencer
    import stim_seq_pkg::*;
#(
    parameter int unsigned DEPTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [4:0]       wr_addr,
    input  logic [IN_W-1:0]  wr_data,
    input  logic             start,
    input  logic [5:0]       num_vec,
    input  logic [3:0]       settle,
    input  logic [SIG_W-1:0] golden,
    input  logic [OUT_W-1:0] dut_y,
    output logic [IN_W-1:0]  dut_in,
    output logic             busy,
    output logic             cap_valid,
    output logic [4:0]       cap_idx,
    output logic [SIG_W-1:0] signature,
    output logic             done,
    output logic             pass
);

    logic [IN_W-1:0] mem [DEPTH];

    seq_state_t state;
    logic [4:0] idx;
    logic [4:0] idx_nxt;
    logic [5:0] n_q;
    logic [3:0] s_q;
    logic [3:0] cnt;
    logic       start_ok;
    logic       last_vec;
    logic       misr_en;

    // A start is only honoured from idle with a non-empty run.
    always_comb begin
        start_ok = (state == StIdle) && start && (num_vec != 6'd0);
        idx_nxt  = idx + 5'd1;
        last_vec = ({1'b0, idx} == (n_q - 6'd1));
        misr_en  = (state == StCapture);
    end

    // Vector store: not reset, and frozen while a run is reading it.
    always_ff @(posedge clk) begin
        if (wr_en && !busy) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Run control FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= StIdle;
            dut_in    <= '0;
            busy      <= 1'b0;
            cap_valid <= 1'b0;
            cap_idx   <= '0;
            done      <= 1'b0;
            pass      <= 1'b0;
            idx       <= '0;
            n_q       <= '0;
            s_q       <= '0;
            cnt       <= '0;
        end else begin
            cap_valid <= 1'b0;
            done      <= 1'b0;
            case (state)
                StIdle: begin
                    if (start_ok) begin
                        n_q    <= num_vec;
                        s_q    <= settle;
                        cnt    <= settle;
                        idx    <= '0;
                        dut_in <= mem[0];
                        pass   <= 1'b0;
                        busy   <= 1'b1;
                        state  <= (settle == 4'd0) ? StCapture : StSettle;
                    end
                end
                StSettle: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= StCapture;
                    end
                end
                StCapture: begin
                    cap_valid <= 1'b1;
                    cap_idx   <= idx;
                    if (last_vec) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= StDone;
                    end else begin
                        idx    <= idx_nxt;
                        dut_in <= mem[idx_nxt];
                        cnt    <= s_q;
                        state  <= (s_q == 4'd0) ? StCapture : StSettle;
                    end
                end
                StDone: begin
                    pass  <= (signature == golden);
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

    stim_misr u_misr (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (start_ok),
        .en    (misr_en),
        .data  (dut_y),
        .sig   (signature)
    );

endmodule

// File: tb/tb_stim_sequencer.sv
// Directed self-checking bench for stim_sequencer.
module tb_stim_sequencer;

    localparam int unsigned OUT_W = 474;
    localparam logic [31:0] POLY  = 32'h04C1_1DB7;

    logic              clk;
    logic              rst_n;
    logic              wr_en;
    logic [4:0]        wr_addr;
    logic [63:0]       wr_data;
    logic              start;
    logic [5:0]        num_vec;
    logic [3:0]        settle;
    logic [31:0]       golden;
    logic [OUT_W-1:0]  dut_y;
    logic [63:0]       dut_in;
    logic              busy;
    logic              cap_valid;
    logic [4:0]        cap_idx;
    logic [31:0]       signature;
    logic              done;
    logic              pass;

    logic              y_en;
    logic [63:0]       vec [21];
    logic [31:0]       model;
    int                n_cmp;
    int                n_err;

    stim_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .start     (start),
        .num_vec   (num_vec),
        .settle    (settle),
        .golden    (golden),
        .dut_y     (dut_y),
        .dut_in    (dut_in),
        .busy      (busy),
        .cap_valid (cap_valid),
        .cap_idx   (cap_idx),
        .signature (signature),
        .done      (done),
        .pass      (pass)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [OUT_W-1:0] ymap(input logic [63:0] v);
        return {{(OUT_W-128){1'b0}}, ~v, v};
    endfunction

    // Stand-in for the datapath: a simple function of the driven vector.
    always_comb begin
        dut_y = y_en ? ymap(dut_in) : '0;
    end

    function automatic logic [31:0] misr_next(input logic [31:0] s, input logic [OUT_W-1:0] y);
        logic [479:0] p;
        logic [31:0]  f;
        p = {6'b0, y};
        f = '0;
        for (int i = 0; i < 15; i++) f = f ^ p[i*32 +: 32];
        return {s[30:0], 1'b0} ^ (s[31] ? POLY : 32'h0) ^ f;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " dut_in"}, dut_in, 64'h0);
        chk({tag, " busy"}, 64'(busy), 64'h0);
        chk({tag, " cap_valid"}, 64'(cap_valid), 64'h0);
        chk({tag, " cap_idx"}, 64'(cap_idx), 64'h0);
        chk({tag, " done"}, 64'(done), 64'h0);
        chk({tag, " pass"}, 64'(pass), 64'h0);
        chk({tag, " signature"}, 64'(signature), 64'hFFFF_FFFF);
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        start   = 1'b0;
        num_vec = '0;
        settle  = '0;
        golden  = '0;
        y_en    = 1'b1;
        for (int k = 0; k < 21; k++) begin
            vec[k] = {10'(k*37+3), 11'(k*101+5), 22'(k*12345+7), 21'(k*7777+1)};
        end

        // 1: reset and idle
        tick();
        tick();
        chk_reset_vals("reset");
        rst_n = 1'b1;
        wr_en = 1'b1;
        for (int k = 0; k < 21; k++) begin
            wr_addr = 5'(k);
            wr_data = vec[k];
            tick();
        end
        wr_en   = 1'b0;
        num_vec = 6'd0;
        start   = 1'b1;
        tick();
        start = 1'b0;
        chk("zero_n busy", 64'(busy), 64'h0);
        tick();
        chk("zero_n busy2", 64'(busy), 64'h0);
        chk("zero_n done", 64'(done), 64'h0);

        // 2: back-to-back drive, N=21 S=0
        model = 32'hFFFF_FFFF;
        for (int k = 0; k < 21; k++) model = misr_next(model, ymap(vec[k]));
        golden  = model;
        num_vec = 6'd21;
        settle  = 4'd0;
        start   = 1'b1;
        tick();
        start = 1'b0;
        chk("b2b busy", 64'(busy), 64'h1);
        for (int k = 0; k < 21; k++) begin
            chk($sformatf("b2b dut_in[%0d]", k), dut_in, vec[k]);
            chk($sformatf("b2b done_early[%0d]", k), 64'(done), 64'h0);
            tick();
            chk($sformatf("b2b cap_valid[%0d]", k), 64'(cap_valid), 64'h1);
            chk($sformatf("b2b cap_idx[%0d]", k), 64'(cap_idx), 64'(k));
        end
        chk("b2b done", 64'(done), 64'h1);
        chk("b2b busy_end", 64'(busy), 64'h0);
        chk("b2b signature", 64'(signature), 64'(model));
        tick();
        chk("b2b pass", 64'(pass), 64'h1);
        chk("b2b done_pulse", 64'(done), 64'h0);
        chk("b2b dut_in_hold", dut_in, vec[20]);

        // 3: settle spacing N=3 S=2, plus start during DONE ignored
        num_vec = 6'd3;
        settle  = 4'd2;
        start   = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            chk($sformatf("settle cap_valid@%0d", c), 64'(cap_valid),
                64'((c == 3) || (c == 6) || (c == 9)));
            chk($sformatf("settle done@%0d", c), 64'(done), 64'(c == 9));
            chk($sformatf("settle busy@%0d", c), 64'(busy), 64'(c <= 8));
            chk($sformatf("settle dut_in@%0d", c), dut_in, vec[(c / 3 > 2) ? 2 : c / 3]);
            if (c == 3 || c == 6 || c == 9)
                chk($sformatf("settle cap_idx@%0d", c), 64'(cap_idx), 64'(c / 3 - 1));
            start = (c == 9);
        end
        start = 1'b0;

        // 4: signature with dut_y tied to zero
        y_en    = 1'b0;
        golden  = 32'hFB3E_E249;
        num_vec = 6'd1;
        settle  = 4'd0;
        start   = 1'b1;
        tick();
        start = 1'b0;
        chk("sig busy", 64'(busy), 64'h1);
        tick();
        chk("sig done", 64'(done), 64'h1);
        chk("sig value", 64'(signature), 64'hFB3E_E249);
        tick();
        chk("sig pass", 64'(pass), 64'h1);
        golden = 32'hFB3E_E248;
        start  = 1'b1;
        tick();
        start = 1'b0;
        chk("sig pass_cleared", 64'(pass), 64'h0);
        tick();
        chk("sig value2", 64'(signature), 64'hFB3E_E249);
        tick();
        chk("sig fail_golden", 64'(pass), 64'h0);
        y_en = 1'b1;

        // 5: write and start blocked while busy, N=3 S=1
        num_vec = 6'd3;
        settle  = 4'd1;
        start   = 1'b1;
        tick();
        wr_en   = 1'b1;
        wr_addr = 5'd0;
        wr_data = 64'hDEAD_BEEF_CAFE_F00D;
        num_vec = 6'd1;
        settle  = 4'd0;
        tick();
        wr_en = 1'b0;
        start = 1'b0;
        chk("block busy", 64'(busy), 64'h1);
        tick();
        tick();
        tick();
        tick();
        chk("block no_early_done", 64'(done), 64'h0);
        tick();
        chk("block done", 64'(done), 64'h1);
        chk("block cap_idx", 64'(cap_idx), 64'h2);
        tick();
        num_vec = 6'd1;
        start   = 1'b1;
        tick();
        start = 1'b0;
        chk("block mem0", dut_in, vec[0]);
        tick();
        chk("block done2", 64'(done), 64'h1);
        tick();

        // 6: reset mid-run at vector 5 of 10
        num_vec = 6'd10;
        settle  = 4'd0;
        start   = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        chk("midrst vec5", dut_in, vec[5]);
        rst_n = 1'b0;
        tick();
        chk_reset_vals("midrst");
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            chk($sformatf("midrst no_done[%0d]", k), 64'(done), 64'h0);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("replay vec0", dut_in, vec[0]);
        tick();
        chk("replay vec1", dut_in, vec[1]);
        for (int k = 0; k < 12; k++) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/stim_sequencer.md
# stim_sequencer

Self-checking stimulus controller for the fuzzed `top` datapath (64-bit packed input {wire0, wire1, wire2, wire3}, 474-bit output `y`). It holds a preloaded vector store and drives one vector per step into `top`. After a programmable settle time it samples `y` and compresses every sample into a 32-bit MISR signature, then flags pass/fail against a golden signature. This replaces the free-running `#10` vector lists with a synthesizable, cycle-exact sequencer that can sit beside `top` on hardware.

## Interface
- `DEPTH`, 32: vector store entries; `num_vec` range 1..DEPTH.
- `IN_W`, 64: packed DUT input width; bits 63:54 = wire0, 53:43 = wire1, 42:21 = wire2, 20:0 = wire3.
- `OUT_W`, 474: DUT output width (`y[473:0]`).
- `SIG_W`, 32: signature width.

Ports:
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `wr_en`  in  1  vector store write strobe; ignored while `busy`.
- `wr_addr`  in  5  store address.
- `wr_data`  in  IN_W  vector to store.
- `start`  in  1  begin a run; ignored while `busy` or when `num_vec` == 0.
- `num_vec`  in  6  number of vectors in the run; latched on `start`.
- `settle`  in  4  extra cycles between drive and sample; latched on `start`.
- `golden`  in  SIG_W  expected final signature; sampled in the DONE cycle.
- `dut_y`  in  OUT_W  `top.y`.
- `dut_in`  out  IN_W  registered vector to `top`.
- `busy`  out  1  run in progress.
- `cap_valid`  out  1  one-cycle pulse after each sample.
- `cap_idx`  out  5  index of the vector just sampled; valid with `cap_valid`.
- `signature`  out  SIG_W  running MISR value.
- `done`  out  1  one-cycle pulse at end of run.
- `pass`  out  1  `signature == golden` at DONE; held until the next `start`.

## Operation
- FSM states: IDLE, SETTLE, CAPTURE, DONE.
- **IDLE, accepted `start`:**
  - latch `num_vec` → N and `settle` → S;
  - `idx` ← 0, `dut_in` ← mem[0], `signature` ← 32'hFFFF_FFFF, `pass` ← 0;
  - go to SETTLE with counter = S, or directly to CAPTURE if S == 0.
- **SETTLE:** decrement the counter; go to CAPTURE at the edge where it reaches 0.
- **CAPTURE edge:**
  - sample `dut_y` and update the MISR;
  - register `cap_valid` = 1 and `cap_idx` = `idx`.
  - If `idx` == N−1, go to DONE.
  - Otherwise `idx`++, `dut_in` ← mem[idx+1], and go to SETTLE or CAPTURE per S.
- **DONE (one cycle):**
  - `done` = 1;
  - `pass` ← (`signature` == `golden`);
  - return to IDLE.
- **MISR update:**
  - fold = XOR of the 15 32-bit slices of {6'b0, `dut_y`};
  - sig ← {sig[30:0], 1'b0} ^ (sig[31] ? 32'h04C1_1DB7 : 0) ^ fold.
- `dut_in` holds the last vector after a run; no zero return.
- The vector store is not reset; contents survive `rst_n`.
- A write to the same address as a simultaneous run read is impossible, because writes are blocked while `busy`.

## Timing
- **Reset values:**
  - `dut_in` = 0, `busy` = 0, `cap_valid` = 0, `cap_idx` = 0, `done` = 0, `pass` = 0;
  - `signature` = 32'hFFFF_FFFF;
  - state = IDLE.
- **Reset mid-run:** abort at that edge, all outputs return to reset values, and no `done` is issued.
- **Capture schedule:** with the start edge as e0, vector k is driven from edge e0 + k(S+1) and sampled at edge e0 + (k+1)(S+1).
- `cap_valid` is high in the cycle after each sample edge.
- `busy` is high from the cycle after e0 through the final sample edge.
- `done` is high in the cycle after the final sample edge, with `signature` final in that same cycle.
- Run length is N(S+1) + 1 cycles from `start` to the `done` cycle. With S = 0, one vector is applied per clock.
- `start` asserted in the DONE cycle is ignored; it is accepted once the FSM is back in IDLE.

## Structure
- Package `stim_seq_pkg` contains:
  - `IN_W`, `OUT_W`, `SIG_W`;
  - `MISR_POLY` = 32'h04C1_1DB7 and `MISR_SEED` = 32'hFFFF_FFFF;
  - the FSM state enum `seq_state_t`.
- Sub-module `stim_misr` (fold plus shift/update, with `clear` and `en` inputs) is instantiated once.
- The vector store is an inferred register array inside `stim_sequencer`.

## Test plan
1. **Reset and idle:** assert `rst_n` = 0 for 2 cycles. Required: every output at its reset value and `signature` = 32'hFFFF_FFFF. `start` with `num_vec` = 0 → `busy` stays 0.
2. **Back-to-back drive:**
   - Stimulus: load the 21 vectors used by the existing `top` bench; N = 21, S = 0.
   - `dut_in` equals mem[k] for k = 0..20 on consecutive cycles.
   - 21 `cap_valid` pulses occur with `cap_idx` = 0..20.
   - `done` is asserted 22 cycles after `start`.
3. **Settle spacing:** N = 3, S = 2. Required: samples at edges e0+3, e0+6 and e0+9; `done` in the cycle after e0+9.
4. **Signature check:**
   - Stimulus: tie `dut_y` = 0, N = 1, S = 0.
   - Required: `signature` = 32'hFB3E_E249 (the seed shifted with the poly applied).
   - Required: `golden` = 32'hFB3E_E249 → `pass` = 1; any other `golden` → `pass` = 0.
5. **Blocked inputs:**
   - Stimulus: `wr_en` to address 0 and a second `start` during a run.
   - Required: mem[0] is unchanged and the run is unaffected.
6. **Mid-run reset:**
   - Stimulus: `rst_n` = 0 at vector 5 of 10.
   - Required: no `done` and outputs at reset values.
   - Required: a fresh `start` replays from vector 0 with the store intact.
